cic_decimator: RTL and testbench

- Order-N cascaded integrator-comb (CIC) decimation filter.
- Decimation ratio R = 2^DECIMATION_BITS; differential delay M = 1.
- Takes the signed mixer output (I or Q) at the sampling-clock rate and produces a full-precision, low-rate result plus a decimated clock.
- Sits between the phase-sensitive detector and the packet transmitter; the transmitter triggers on the rising edge of o_clk.

---
 rtl/cic_integrator_stage.sv | 23 ++
 rtl/cic_decimator.sv | 82 ++++++++
 tb/tb_cic_decimator.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/cic_integrator_stage.sv
// Single CIC integrator: a wide accumulator that adds its input every enabled
// sampling cycle. Arithmetic wraps modulo 2^WIDTH, and the filter relies on
// that wrap.
module cic_integrator_stage #(
    parameter int WIDTH = 106
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] din,
    output logic signed [WIDTH-1:0] acc
);

    // Accumulate the input on every enabled cycle; clear asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + din;
        end
    end

endmodule

// File: rtl/cic_decimator.sv
// Order-N cascaded integrator-comb decimator with differential delay 1.
// The integrators run at the sampling rate. The combs run once per R = 2^DECIMATION_BITS
// enabled cycles. o_clk is the decimation counter MSB, so its rising edge falls
// half a period after each o_data update.
module cic_decimator #(
    parameter  int I_WIDTH         = 16,
    parameter  int ORDER           = 5,
    parameter  int DECIMATION_BITS = 18,
    localparam int O_WIDTH         = I_WIDTH + ORDER * DECIMATION_BITS
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_en,
    input  logic signed [I_WIDTH-1:0] i_data,
    output logic signed [O_WIDTH-1:0] o_data,
    output logic                      o_clk
);

    logic [DECIMATION_BITS-1:0] dec_count;
    logic [DECIMATION_BITS-1:0] dec_count_next;
    logic                       strobe;

    logic signed [O_WIDTH-1:0] integ [ORDER];
    logic signed [O_WIDTH-1:0] comb_c [ORDER];
    logic signed [O_WIDTH-1:0] comb_d [ORDER];
    logic signed [O_WIDTH-1:0] comb_out;

    assign dec_count_next = dec_count + DECIMATION_BITS'(1);
    assign strobe         = i_en && (dec_count == '1);

    // Integrator cascade: stage 0 takes the sign-extended sample, later stages take the previous register.
    for (genvar k = 0; k < ORDER; k++) begin : g_integ
        logic signed [O_WIDTH-1:0] stage_in;
        if (k == 0) begin : g_first
            assign stage_in = {{(O_WIDTH - I_WIDTH){i_data[I_WIDTH-1]}}, i_data};
        end else begin : g_rest
            assign stage_in = integ[k-1];
        end
        cic_integrator_stage #(
            .WIDTH (O_WIDTH)
        ) u_stage (
            .clk   (i_clk),
            .rst_n (i_rst),
            .en    (i_en),
            .din   (stage_in),
            .acc   (integ[k])
        );
    end

    // Comb chain: each stage subtracts its value from the previous strobe, evaluated within the strobe cycle.
    always_comb begin
        logic signed [O_WIDTH-1:0] running;
        running = integ[ORDER-1];
        for (int k = 0; k < ORDER; k++) begin
            comb_c[k] = running;
            running   = running - comb_d[k];
        end
        comb_out = running;
    end

    // Decimation counter, o_clk and the comb delay/output registers, all frozen when i_en is low.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            dec_count <= '0;
            o_clk     <= 1'b0;
            o_data    <= '0;
            for (int k = 0; k < ORDER; k++) begin
                comb_d[k] <= '0;
            end
        end else if (i_en) begin
            dec_count <= dec_count_next;
            o_clk     <= dec_count_next[DECIMATION_BITS-1];
            if (strobe) begin
                for (int k = 0; k < ORDER; k++) begin
                    comb_d[k] <= comb_c[k];
                end
                o_data <= comb_out;
            end
        end
    end

endmodule

// File: tb/tb_cic_decimator.sv
// Directed bench for the CIC decimator. It uses two small instances that share
// the same stimulus:
//   - dut1: ORDER=1, R=4, I_WIDTH=4, so O_WIDTH=6 and the DC gain is 4.
//   - dut2: ORDER=2, R=4, I_WIDTH=4, so O_WIDTH=8 and the DC gain is 16.
// The expected values below are hand-derived from the integrator and comb recurrences.
module tb_cic_decimator;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_en;
    logic [3:0] i_data;
    logic [5:0] o1_data;
    logic       o1_clk;
    logic [7:0] o2_data;
    logic       o2_clk;

    int vectors     = 0;
    int miscompares = 0;

    // Free-running sampling clock.
    always #5 i_clk = ~i_clk;

    cic_decimator #(
        .I_WIDTH         (4),
        .ORDER           (1),
        .DECIMATION_BITS (2)
    ) dut1 (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (i_en),
        .i_data (i_data),
        .o_data (o1_data),
        .o_clk  (o1_clk)
    );

    cic_decimator #(
        .I_WIDTH         (4),
        .ORDER           (2),
        .DECIMATION_BITS (2)
    ) dut2 (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (i_en),
        .i_data (i_data),
        .o_data (o2_data),
        .o_clk  (o2_clk)
    );

    task automatic check_output(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Advance n rising edges, leaving the bench 1 time unit after the last edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] x, input int n);
        i_data = x;
        tick(n);
    endtask

    // Release the reset 1 time unit after an edge, so the next edge is enabled cycle t=0.
    task automatic do_reset();
        i_rst = 1'b0;
        tick(2);
        i_rst = 1'b1;
    endtask

    initial begin
        i_rst  = 1'b0;
        i_en   = 1'b1;
        i_data = 4'd3;

        // Reset held with the clock running.
        tick(3);
        check_output("rst o1_data", 8'(o1_data), 8'h00);
        check_output("rst o1_clk",  8'(o1_clk),  8'h00);
        check_output("rst o2_data", o2_data,     8'h00);
        check_output("rst o2_clk",  8'(o2_clk),  8'h00);

        // Constant +1: dut2 gives 3, 15, 16; dut1 gives 3, 4.
        i_rst = 1'b1;
        apply_stimulus(4'd1, 1);
        check_output("p1 o1_clk cnt1", 8'(o1_clk), 8'h00);
        tick(1);
        check_output("p1 o2_clk cnt2", 8'(o2_clk), 8'h01);
        tick(1);
        check_output("p1 o2_data pre-strobe", o2_data, 8'h00);
        check_output("p1 o2_clk cnt3", 8'(o2_clk), 8'h01);
        tick(1);
        check_output("p1 o2_data s1", o2_data,     8'h03);
        check_output("p1 o1_data s1", 8'(o1_data), 8'h03);
        check_output("p1 o2_clk cnt0", 8'(o2_clk), 8'h00);
        tick(4);
        check_output("p1 o2_data s2", o2_data,     8'h0F);
        check_output("p1 o1_data s2", 8'(o1_data), 8'h04);
        tick(4);
        check_output("p1 o2_data s3", o2_data,     8'h10);
        tick(2);
        check_output("p1 o2_data hold", o2_data,   8'h10);
        tick(2);
        check_output("p1 o2_data s4", o2_data,     8'h10);
        check_output("p1 o1_data s4", 8'(o1_data), 8'h04);

        // Constant -1: dut2 gives -3, -15, -16; dut1 gives -3, -4.
        do_reset();
        apply_stimulus(4'hF, 4);
        check_output("m1 o2_data s1", o2_data,     8'hFD);
        check_output("m1 o1_data s1", 8'(o1_data), 8'h3D);
        tick(4);
        check_output("m1 o2_data s2", o2_data,     8'hF1);
        check_output("m1 o1_data s2", 8'(o1_data), 8'h3C);
        tick(4);
        check_output("m1 o2_data s3", o2_data,     8'hF0);

        // Constant -8, the most negative input: dut2 gives -128, dut1 gives -32.
        do_reset();
        apply_stimulus(4'h8, 12);
        check_output("m8 o2_data", o2_data,     8'h80);
        check_output("m8 o1_data", 8'(o1_data), 8'h20);

        // Constant +7, the most positive input: dut2 gives 112, dut1 gives 28.
        do_reset();
        apply_stimulus(4'h7, 12);
        check_output("p7 o2_data", o2_data,     8'h70);
        check_output("p7 o1_data", 8'(o1_data), 8'h1C);

        // Enable gating: 5 frozen cycles delay the second strobe from edge 8 to edge 13.
        do_reset();
        apply_stimulus(4'd1, 6);
        check_output("en pre o2_data", o2_data, 8'h03);
        i_en = 1'b0;
        apply_stimulus(4'd7, 5);
        check_output("en frz o2_data", o2_data,     8'h03);
        check_output("en frz o2_clk",  8'(o2_clk),  8'h01);
        check_output("en frz o1_data", 8'(o1_data), 8'h03);
        check_output("en frz o1_clk",  8'(o1_clk),  8'h01);
        i_en = 1'b1;
        apply_stimulus(4'd1, 1);
        check_output("en res cnt3 o2_data", o2_data, 8'h03);
        tick(1);
        check_output("en res s2 o2_data", o2_data,     8'h0F);
        check_output("en res s2 o1_data", 8'(o1_data), 8'h04);
        check_output("en res s2 o2_clk",  8'(o2_clk),  8'h00);
        tick(4);
        check_output("en res s3 o2_data", o2_data, 8'h10);

        // Asynchronous reset between edges while settled at 16.
        #3;
        i_rst = 1'b0;
        #1;
        check_output("arst o2_data", o2_data,     8'h00);
        check_output("arst o1_data", 8'(o1_data), 8'h00);
        check_output("arst o2_clk",  8'(o2_clk),  8'h00);
        tick(1);
        i_rst = 1'b1;
        apply_stimulus(4'd1, 12);
        check_output("arst resettle o2_data", o2_data, 8'h10);

        // Alternating +1/-1 has a zero at fs/2, so both outputs settle to 0.
        do_reset();
        for (int t = 0; t < 16; t++) begin
            apply_stimulus(((t % 2) == 1) ? 4'hF : 4'h1, 1);
            if (t == 3) begin
                check_output("alt s1 o2_data", o2_data,     8'h01);
                check_output("alt s1 o1_data", 8'(o1_data), 8'h01);
            end
            if (t == 7) begin
                check_output("alt s2 o2_data", o2_data,     8'h01);
                check_output("alt s2 o1_data", 8'(o1_data), 8'h00);
            end
            if (t == 11 || t == 15) begin
                check_output("alt settled o2_data", o2_data,     8'h00);
                check_output("alt settled o1_data", 8'(o1_data), 8'h00);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
